n64_poll_responder: RTL and testbench
=====================================

Name: n64_poll_responder

Overview:
- Controller-side N64 joybus front end: filters the raw data line, decodes 8-bit console commands, and answers poll (0x01) with a 32-bit controller-state frame.
- Sits between the bidirectional pad (external tristate driven by n64d_out/n64d_oe) and the input-source mux.
- Other commands are only reported on command/command_valid. Identity replies are handled elsewhere.

Parameters:
- CLK_PER_US, 50, sys_clk cycles per microsecond.
- FILTER_LEN, 4, consecutive identical samples needed before the filtered line changes.
- TURNAROUND_CYC, 100, cycles from poll command_valid to the first driven response edge.
- IDLE_TIMEOUT_CYC, 300, high-time that aborts a partial command.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- n64d_in  in  1  raw (asynchronous) data-line level.
- data  in  32  controller state; bit31 is sent first.
- n64d_out  out  1  level to drive onto the line.
- n64d_oe  out  1  1 = pad drives n64d_out; 0 = tristate.
- command  out  8  last decoded command byte.
- command_valid  out  1  one-cycle pulse when command updates.
- busy  out  1  high from poll acceptance until the response stop bit is released.

Behaviour:
- Reset (async, reset_n=0) forces: n64d_out=1, n64d_oe=0, command=0, command_valid=0, busy=0, filtered line=1, all counters=0, FSM=IDLE.
- Reset mid-receive or mid-transmit aborts immediately; nothing resumes after release.
- Filter:
  - 2-flop synchronizer on n64d_in, then stability counter.
  - Filtered output takes a new level only after FILTER_LEN consecutive equal synchronized samples.
  - Low pulses shorter than FILTER_LEN cycles are invisible.
  - Latency from input edge to filtered edge: 2+FILTER_LEN cycles.
- Receiver (enabled only when busy=0):
  - Each falling edge of the filtered line starts a low-time counter.
  - On the rising edge, bit = 1 if low time < 2*CLK_PER_US (100), else 0.
  - Bits are shifted MSB first.
  - After 8 data bits, the next low pulse is the stop bit. On its rising edge, command <= shifted byte and command_valid pulses for 1 cycle.
  - Further pulses are then ignored until the line stays high IDLE_TIMEOUT_CYC cycles.
  - If the line stays high for IDLE_TIMEOUT_CYC while 1..8 bits (or the stop bit) are outstanding, the partial byte is discarded: no command_valid, bit counter = 0.
  - The low-time counter saturates; it must not wrap.
- Poll FSM, states IDLE -> TURNAROUND -> SEND_BIT -> SEND_STOP -> IDLE:
  - IDLE: on command_valid with command==0x01, set busy=1, go to TURNAROUND. Any other command leaves the FSM in IDLE.
  - TURNAROUND: count TURNAROUND_CYC cycles with n64d_oe=0. On exit, latch data into a shift register; later changes on data do not affect this frame.
  - SEND_BIT: n64d_oe=1. Each bit lasts 4*CLK_PER_US (200) cycles.
    - Bit 0: n64d_out low for 150 cycles, then high for 50.
    - Bit 1: n64d_out low for 50 cycles, then high for 150.
    - 32 bits are sent, bit31 first.
  - SEND_STOP: n64d_out low for 2*CLK_PER_US (100) cycles, then n64d_out=1, n64d_oe=0, busy=0, return to IDLE.
  - Timing: first falling edge at TURNAROUND_CYC cycles after command_valid; total drive time 6500 cycles.
- While busy=1:
  - The receiver is held cleared, so the FSM's own transmission is not decoded.
  - A fresh command is decoded only after busy falls and a new falling edge occurs.
- Simultaneous events: reset dominates everything. command_valid cannot coincide with busy=1.

Test Plan:
- Send 0x01 + stop (console encoding 3us/1us, 1us/3us, data=0x80FF7F01) -> command=0x01, single command_valid pulse. After 100 cycles, 32 response bits: low times 50 (bit 1) or 150 (bit 0), decoding to 0x80FF7F01. Then a 100-cycle stop low, then oe=0, busy=0.
- Send 0x00, then 0xFF -> command_valid each time with matching byte. n64d_oe stays 0 and busy stays 0.
- Inject 2- and 3-cycle low glitches on an idle line and inside a high phase -> filtered line unchanged, decoded byte unaffected. A 4-cycle low is seen as a falling edge.
- Send 5 bits, then hold high for 300 cycles, then a full 0x01 -> no command_valid for the partial burst; a correct response follows the full command.
- Assert reset_n=0 during response bit 10 -> n64d_oe=0, n64d_out=1, busy=0 immediately. After release, a new 0x01 gets a complete 32-bit response.
- Change data during TURNAROUND and again during SEND_BIT -> the transmitted frame equals data at the TURNAROUND exit.

Source files
------------

// File: rtl/n64_poll_responder.sv
`default_nettype none
// ============================================================================
//  Module   : n64_poll_responder
//  Purpose  : Controller-side N64 joybus front end. Filters the raw data
//             line, decodes 8-bit console commands, and answers the poll
//             command (0x01) with a 32-bit controller-state frame.
//  Ports    : sys_clk       - system clock (CLK_PER_US cycles per us)
//             reset_n       - asynchronous active-low reset
//             n64d_in       - raw asynchronous data-line level
//             data[31:0]    - controller state, bit31 transmitted first
//             n64d_out      - level for the pad to drive
//             n64d_oe       - 1 = pad drives n64d_out, 0 = tristate
//             command[7:0]  - last decoded command byte
//             command_valid - one-cycle pulse when command updates
//             busy          - high from poll acceptance to stop-bit release
//  Revision : 1.0 - initial release
// ============================================================================
module n64_poll_responder #(
    parameter int CLK_PER_US       = 50,
    parameter int FILTER_LEN       = 4,
    parameter int TURNAROUND_CYC   = 100,
    parameter int IDLE_TIMEOUT_CYC = 300
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        n64d_in,
    input  logic [31:0] data,
    output logic        n64d_out,
    output logic        n64d_oe,
    output logic [7:0]  command,
    output logic        command_valid,
    output logic        busy
);

    // ------------------------------------------------------------------
    // Derived timing constants and counter widths
    // ------------------------------------------------------------------
    localparam int c_bit_cyc  = 4 * CLK_PER_US;   // one response bit cell
    localparam int c_stop_cyc = 2 * CLK_PER_US;   // response stop-bit low time
    localparam int c_thresh   = 2 * CLK_PER_US;   // receive 1/0 decision point
    localparam int c_flt_w    = $clog2(FILTER_LEN + 1);
    localparam int c_cnt_w    = $clog2(IDLE_TIMEOUT_CYC + c_bit_cyc + 1);
    localparam int c_ph_w     = $clog2(c_bit_cyc + 1);
    localparam int c_ta_w     = $clog2(TURNAROUND_CYC + 1);

    localparam logic [c_flt_w-1:0] c_flt_last  = c_flt_w'(FILTER_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_bit_thr   = c_cnt_w'(c_thresh);
    localparam logic [c_cnt_w-1:0] c_idle_thr  = c_cnt_w'(IDLE_TIMEOUT_CYC);
    localparam logic [c_ph_w-1:0]  c_one_low   = c_ph_w'(CLK_PER_US);
    localparam logic [c_ph_w-1:0]  c_zero_low  = c_ph_w'(3 * CLK_PER_US);
    localparam logic [c_ph_w-1:0]  c_bit_last  = c_ph_w'(c_bit_cyc - 1);
    localparam logic [c_ph_w-1:0]  c_stop_last = c_ph_w'(c_stop_cyc - 1);
    // Entry into TURNAROUND already costs one cycle after command_valid and
    // the exit edge is the first driven cycle, hence the "-2".
    localparam logic [c_ta_w-1:0]  c_ta_last   = c_ta_w'(TURNAROUND_CYC - 2);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_turn = 2'd1;
    localparam logic [1:0] c_st_bit  = 2'd2;
    localparam logic [1:0] c_st_stop = 2'd3;

    localparam logic [7:0] c_cmd_poll = 8'h01;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic               sync1_q, sync2_q;
    logic               filt_q, filt_d, filt_prev_q;
    logic [c_flt_w-1:0] flt_cnt_q, flt_cnt_d;

    logic [c_cnt_w-1:0] lowcnt_q, lowcnt_d;
    logic [c_cnt_w-1:0] highcnt_q, highcnt_d;
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               done_q, done_d;
    logic               armed_q, armed_d;
    logic [7:0]         cmd_q, cmd_d;
    logic               valid_q, valid_d;

    logic [1:0]         state_q, state_d;
    logic [c_ta_w-1:0]  ta_cnt_q, ta_cnt_d;
    logic [c_ph_w-1:0]  ph_q, ph_d;
    logic [4:0]         idx_q, idx_d;
    logic [31:0]        sr_q, sr_d;
    logic               out_q, out_d;
    logic               oe_q, oe_d;

    logic               w_busy;
    logic               w_fall;
    logic               w_rise;
    logic               w_idle;
    logic               w_bit;

    // ------------------------------------------------------------------
    // Input synchronizer and stability filter
    // ------------------------------------------------------------------
    // The filtered level only moves after FILTER_LEN consecutive samples
    // disagree with it; any agreeing sample restarts the count.
    always_comb begin
        flt_cnt_d = '0;
        filt_d    = filt_q;
        if (sync2_q != filt_q) begin
            if (flt_cnt_q == c_flt_last) begin
                filt_d = sync2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            flt_cnt_q   <= '0;
        end else begin
            sync1_q     <= n64d_in;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            flt_cnt_q   <= flt_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Command receiver
    // ------------------------------------------------------------------
    assign w_busy = (state_q != c_st_idle);
    assign w_fall = filt_prev_q & ~filt_q;
    assign w_rise = ~filt_prev_q & filt_q;
    assign w_idle = filt_q & (highcnt_q >= c_idle_thr);
    // On the rise cycle lowcnt_q holds the exact number of low cycles.
    assign w_bit  = (lowcnt_q < c_bit_thr);

    always_comb begin
        // Both run-length counters saturate instead of wrapping.
        if (filt_q) begin
            lowcnt_d = '0;
        end else if (lowcnt_q == '1) begin
            lowcnt_d = lowcnt_q;
        end else begin
            lowcnt_d = lowcnt_q + 1'b1;
        end

        if (!filt_q) begin
            highcnt_d = '0;
        end else if (highcnt_q == '1) begin
            highcnt_d = highcnt_q;
        end else begin
            highcnt_d = highcnt_q + 1'b1;
        end

        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        done_d   = done_q;
        armed_d  = armed_q;
        cmd_d    = cmd_q;
        valid_d  = 1'b0;

        if (w_busy) begin
            // Our own transmission must not be decoded, and a rise left over
            // from it must not count: require a fresh fall after busy drops.
            bitcnt_d = '0;
            shift_d  = '0;
            done_d   = 1'b0;
            armed_d  = 1'b0;
        end else begin
            if (w_fall) begin
                armed_d = 1'b1;
            end
            if (w_idle) begin
                // Long high time: drop any partial byte and re-open reception.
                bitcnt_d = '0;
                shift_d  = '0;
                done_d   = 1'b0;
            end else if (w_rise && armed_q && !done_q) begin
                if (bitcnt_q == 4'd8) begin
                    // This pulse was the stop bit.
                    cmd_d    = shift_q;
                    valid_d  = 1'b1;
                    done_d   = 1'b1;
                    bitcnt_d = '0;
                end else begin
                    shift_d  = {shift_q[6:0], w_bit};
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            lowcnt_q  <= '0;
            highcnt_q <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            armed_q   <= 1'b0;
            cmd_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            lowcnt_q  <= lowcnt_d;
            highcnt_q <= highcnt_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            armed_q   <= armed_d;
            cmd_q     <= cmd_d;
            valid_q   <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Poll response FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ta_cnt_d = ta_cnt_q;
        ph_d     = ph_q;
        idx_d    = idx_q;
        sr_d     = sr_q;

        case (state_q)
            c_st_idle: begin
                if (valid_q && (cmd_q == c_cmd_poll)) begin
                    state_d  = c_st_turn;
                    ta_cnt_d = '0;
                end
            end
            c_st_turn: begin
                if (ta_cnt_q == c_ta_last) begin
                    // Frame is frozen here; later data changes are ignored.
                    state_d = c_st_bit;
                    sr_d    = data;
                    ph_d    = '0;
                    idx_d   = '0;
                end else begin
                    ta_cnt_d = ta_cnt_q + 1'b1;
                end
            end
            c_st_bit: begin
                if (ph_q == c_bit_last) begin
                    ph_d = '0;
                    if (idx_q == 5'd31) begin
                        state_d = c_st_stop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        sr_d  = {sr_q[30:0], 1'b0};
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            c_st_stop: begin
                if (ph_q == c_stop_last) begin
                    state_d = c_st_idle;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase

        // Pad controls are derived from the next state so they are glitch-free
        // flops aligned with the state they belong to.
        oe_d = (state_d == c_st_bit) || (state_d == c_st_stop);
        case (state_d)
            c_st_bit:  out_d = (ph_d >= (sr_d[31] ? c_one_low : c_zero_low));
            c_st_stop: out_d = 1'b0;
            default:   out_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= c_st_idle;
            ta_cnt_q <= '0;
            ph_q     <= '0;
            idx_q    <= '0;
            sr_q     <= '0;
            out_q    <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ta_cnt_q <= ta_cnt_d;
            ph_q     <= ph_d;
            idx_q    <= idx_d;
            sr_q     <= sr_d;
            out_q    <= out_d;
            oe_q     <= oe_d;
        end
    end

    assign n64d_out      = out_q;
    assign n64d_oe       = oe_q;
    assign command       = cmd_q;
    assign command_valid = valid_q;
    assign busy          = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_n64_poll_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_n64_poll_responder
//  Purpose  : Scoreboard testbench for n64_poll_responder. Expected command
//             bytes and response frames are queued as stimulus is driven and
//             consumed by a monitor that decodes the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_n64_poll_responder;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        n64d_in = 1'b1;
    logic [31:0] data    = 32'h0;
    logic        n64d_out;
    logic        n64d_oe;
    logic [7:0]  command;
    logic        command_valid;
    logic        busy;

    always #10 sys_clk = ~sys_clk;

    n64_poll_responder dut (
        .sys_clk       (sys_clk),
        .reset_n       (reset_n),
        .n64d_in       (n64d_in),
        .data          (data),
        .n64d_out      (n64d_out),
        .n64d_oe       (n64d_oe),
        .command       (command),
        .command_valid (command_valid),
        .busy          (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_cmd[$];
    logic [31:0] exp_frame[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Output monitor
    // ------------------------------------------------------------------
    int          cyc       = 0;
    int          valid_cyc = -1;
    int          valid_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        prev_oe    = 1'b0;
    logic        in_tx      = 1'b0;
    int          low_run    = 0;
    int          nbits      = 0;
    int          start_cyc  = 0;
    logic [31:0] mon_frame  = 32'h0;

    initial begin
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (!reset_n) begin
                in_tx      = 1'b0;
                prev_oe    = 1'b0;
                prev_valid = 1'b0;
                low_run    = 0;
                nbits      = 0;
            end else begin
                if (command_valid) begin
                    valid_cnt++;
                    chk("valid_single_pulse", prev_valid, 1'b0);
                    chk("busy_at_valid", busy, 1'b0);
                    chk("cmd_was_expected", exp_cmd.size() > 0, 1'b1);
                    if (exp_cmd.size() > 0) begin
                        chk("command", command, exp_cmd.pop_front());
                    end
                    if (command == 8'h01) begin
                        valid_cyc = cyc;
                    end
                end
                if (n64d_oe && !prev_oe) begin
                    in_tx     = 1'b1;
                    start_cyc = cyc;
                    nbits     = 0;
                    low_run   = 0;
                    chk("turnaround", cyc - valid_cyc, 100);
                end
                if (in_tx) begin
                    if (n64d_oe) begin
                        if (!n64d_out) begin
                            low_run++;
                        end else if (low_run > 0) begin
                            if (nbits < 32) begin
                                mon_frame = {mon_frame[30:0], (low_run < 100)};
                                chk("bit_low_time", low_run, (low_run < 100) ? 50 : 150);
                            end
                            nbits++;
                            low_run = 0;
                        end
                    end else begin
                        chk("stop_low_time", low_run, 100);
                        chk("bit_count", nbits, 32);
                        chk("drive_time", cyc - start_cyc, 6500);
                        chk("out_after_tx", n64d_out, 1'b1);
                        chk("busy_after_tx", busy, 1'b0);
                        chk("frame_was_expected", exp_frame.size() > 0, 1'b1);
                        if (exp_frame.size() > 0) begin
                            chk("frame", mon_frame, exp_frame.pop_front());
                        end
                        in_tx = 1'b0;
                    end
                end
                prev_oe    = n64d_oe;
                prev_valid = command_valid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Console bit: 1 = 1us low / 3us high, 0 = 3us low / 1us high.
    // A nonzero g inserts a g-cycle low glitch 20 cycles into the high phase.
    task automatic send_bit(input logic b, input int g);
        int hi;
        hi = b ? 150 : 50;
        n64d_in = 1'b0;
        idle(b ? 50 : 150);
        n64d_in = 1'b1;
        if (g > 0) begin
            idle(20);
            n64d_in = 1'b0;
            idle(g);
            n64d_in = 1'b1;
            idle(hi - 20 - g);
        end else begin
            idle(hi);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c, input int g);
        exp_cmd.push_back(c);
        for (int i = 7; i >= 0; i--) begin
            send_bit(c[i], g);
        end
        n64d_in = 1'b0;
        idle(50);
        n64d_in = 1'b1;
        idle(50);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 8000 && busy; i++) idle(1);
        chk("busy_drop", busy, 1'b0);
        idle(400);
    endtask

    task automatic wait_oe();
        for (int i = 0; i < 500 && !n64d_oe; i++) idle(1);
        chk("oe_rise", n64d_oe, 1'b1);
    endtask

    task automatic quiet_wait(input int n, output logic any_oe, output logic any_busy);
        any_oe   = 1'b0;
        any_busy = 1'b0;
        repeat (n) begin
            @(negedge sys_clk);
            any_oe   = any_oe | n64d_oe;
            any_busy = any_busy | busy;
        end
    endtask

    task automatic glitch(input int n, output logic seen_low);
        seen_low = 1'b0;
        n64d_in  = 1'b0;
        repeat (n) begin
            @(negedge sys_clk);
            if (!dut.filt_q) seen_low = 1'b1;
        end
        n64d_in = 1'b1;
        repeat (12) begin
            @(negedge sys_clk);
            if (!dut.filt_q) seen_low = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic any_oe, any_busy, seen_low;
        int   v0;

        idle(3);
        chk("rst_out", n64d_out, 1'b1);
        chk("rst_oe", n64d_oe, 1'b0);
        chk("rst_command", command, 8'h00);
        chk("rst_valid", command_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_filt", dut.filt_q, 1'b1);
        reset_n = 1'b1;
        idle(400);

        // Basic poll.
        data = 32'h80FF7F01;
        exp_frame.push_back(data);
        send_cmd(8'h01, 0);
        wait_done();

        // Non-poll commands only report.
        send_cmd(8'h00, 0);
        quiet_wait(400, any_oe, any_busy);
        chk("oe_cmd00", any_oe, 1'b0);
        chk("busy_cmd00", any_busy, 1'b0);
        send_cmd(8'hFF, 0);
        quiet_wait(400, any_oe, any_busy);
        chk("oe_cmdFF", any_oe, 1'b0);
        chk("busy_cmdFF", any_busy, 1'b0);

        // Glitches on an idle line.
        v0 = valid_cnt;
        glitch(2, seen_low);
        chk("glitch2_idle", seen_low, 1'b0);
        glitch(3, seen_low);
        chk("glitch3_idle", seen_low, 1'b0);
        glitch(4, seen_low);
        chk("pulse4_seen", seen_low, 1'b1);
        idle(400);
        chk("glitch_no_valid", valid_cnt - v0, 0);

        // Glitches inside high phases do not disturb decoding.
        send_cmd(8'hA5, 3);
        idle(400);
        send_cmd(8'h5A, 2);
        idle(400);

        // Partial burst then idle timeout, then a full poll.
        v0 = valid_cnt;
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        idle(400);
        chk("partial_no_valid", valid_cnt - v0, 0);
        data = 32'h12345678;
        exp_frame.push_back(data);
        send_cmd(8'h01, 0);
        wait_done();

        // Reset during response bit 10; this frame is never completed.
        data = 32'hDEADBEEF;
        send_cmd(8'h01, 0);
        wait_oe();
        idle(10 * 200 + 60);
        reset_n = 1'b0;
        #1;
        chk("midrst_oe", n64d_oe, 1'b0);
        chk("midrst_out", n64d_out, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_command", command, 8'h00);
        idle(5);
        reset_n = 1'b1;
        quiet_wait(400, any_oe, any_busy);
        chk("postrst_oe", any_oe, 1'b0);
        chk("postrst_busy", any_busy, 1'b0);
        data = 32'hC3A50F96;
        exp_frame.push_back(data);
        send_cmd(8'h01, 0);
        wait_done();

        // Data changes during TURNAROUND and SEND_BIT.
        data = 32'h11111111;
        send_cmd(8'h01, 0);
        data = 32'h0F0F55AA;
        exp_frame.push_back(data);
        wait_oe();
        idle(1000);
        data = 32'hFFFFFFFF;
        wait_done();

        chk("cmd_queue_empty", exp_cmd.size(), 0);
        chk("frame_queue_empty", exp_frame.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
